// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for IF/ID and ID/EX latches (load-use, redirect, MEM wait).
// Optional perf counters enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       ex_mem_op,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          mem_err_q, mem_err_d;
  logic          freeze, load_use;
  always_comb begin
    load_use = ex_mem_op == 2'b01 && ex_rd != 5'd0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    freeze = state_q == RUN ? mem_req && !mem_ready : !mem_ready;
    pc_hold = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    idex_flush = 1'b0;
    exmem_stall = 1'b0;
    if (!reset) begin
      pc_hold = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (freeze) begin
      pc_hold = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      exmem_stall = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_hold = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
    state_d = freeze ? MEM_WAIT : RUN;
    // only cycles still waiting count toward the timeout; the completing cycle does not
    wait_d = state_q == RUN ? '0 : (!mem_ready && wait_q != TMO) ? wait_q + WW'(1) : wait_q;
    mem_err_d = mem_err_q || (state_q == MEM_WAIT && wait_d == TMO);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end
  assign mem_err = mem_err_q;
`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             redir;
  assign redir = !freeze && ex_redirect;
  always_comb begin
    stall_d = stall_q + CNT_W'(pc_hold);
    flush_d = flush_q + CNT_W'(redir);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven directed checks of the hazard sequencer plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;
  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] FRZ  = 6'b110101;
  localparam logic [5:0] RDR  = 6'b001010;
  localparam logic [5:0] LDU  = 6'b110010;
  localparam logic [5:0] RST  = 6'b101010;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic [1:0] ex_mem_op = '0;
  logic       pc_hold, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, mem_err;
  logic [7:0] stall_cnt, flush_cnt;
  logic [5:0] outs;
  int         checks = 0, errs = 0;
  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic [1:0] op;
    logic       redir, req, rdy;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [12];
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_op(ex_mem_op), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_hold(pc_hold), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  assign outs = {pc_hold, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rd = v.rd; ex_mem_op = v.op; ex_redirect = v.redir; mem_req = v.req; mem_ready = v.rdy;
  endtask
  task automatic cyc(input string nm, input logic [5:0] exp, input logic exp_err);
    @(negedge clk);
    chk({nm, "_ctl"}, 32'(outs), 32'(exp));
    chk({nm, "_err"}, 32'(mem_err), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask
  task automatic reset_pulse(input string nm);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({nm, "_ctl"}, 32'(outs), 32'(RST));
      chk({nm, "_err"}, 32'(mem_err), 32'd0);
      chk({nm, "_cnt"}, {16'd0, stall_cnt, flush_cnt}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask
  initial begin
    tbl[0]  = '{5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  2'b01, 1'b0, 1'b0, 1'b0, LDU};
    tbl[1]  = '{5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  2'b01, 1'b0, 1'b0, 1'b0, IDLE};
    tbl[2]  = '{5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  2'b10, 1'b0, 1'b0, 1'b0, IDLE};
    tbl[3]  = '{5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  2'b11, 1'b0, 1'b0, 1'b0, IDLE};
    tbl[4]  = '{5'd7,  5'd0,  1'b1, 1'b0, 5'd7,  2'b01, 1'b0, 1'b0, 1'b0, LDU};
    tbl[5]  = '{5'd7,  5'd0,  1'b0, 1'b0, 5'd7,  2'b01, 1'b0, 1'b0, 1'b0, IDLE};
    tbl[6]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  2'b00, 1'b1, 1'b0, 1'b0, RDR};
    tbl[7]  = '{5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  2'b01, 1'b1, 1'b0, 1'b0, RDR};
    tbl[8]  = '{5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  2'b01, 1'b0, 1'b1, 1'b1, LDU};
    tbl[9]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  2'b00, 1'b0, 1'b1, 1'b1, IDLE};
    tbl[10] = '{5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 2'b01, 1'b0, 1'b0, 1'b0, LDU};
    tbl[11] = '{5'd3,  5'd3,  1'b1, 1'b1, 5'd4,  2'b01, 1'b0, 1'b0, 1'b0, IDLE};
    mem_req = 1'b1;
    ex_redirect = 1'b1;
    #2;
    reset_pulse("rst_init");
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i]);
      cyc($sformatf("vec%0d", i), tbl[i].exp, 1'b0);
    end
    apply('{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0, IDLE});
    cyc("ldu_hit", LDU, 1'b0);
    ex_mem_op = 2'b00;
    cyc("ldu_bubble", IDLE, 1'b0);
    apply('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, IDLE});
    for (int k = 1; k <= 10; k++) cyc($sformatf("tmo%0d", k), FRZ, k >= 6);
    reset_pulse("rst_mid_wait");
    apply('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, IDLE});
    cyc("post_rst_run", IDLE, 1'b0);
    apply('{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 2'b01, 1'b1, 1'b1, 1'b0, IDLE});
    for (int k = 1; k <= 4; k++) cyc($sformatf("frz%0d", k), FRZ, 1'b0);
    mem_ready = 1'b1;
    cyc("frz_release", RDR, 1'b0);
    apply('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, IDLE});
    cyc("frz_after", IDLE, 1'b0);
    reset_pulse("rst_cnt");
    apply('{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0, IDLE});
    cyc("cnt_ldu", LDU, 1'b0);
    ex_redirect = 1'b1;
    cyc("cnt_ldu_redir", RDR, 1'b0);
    apply('{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, IDLE});
    cyc("cnt_frz", FRZ, 1'b0);
    mem_ready = 1'b1;
    cyc("cnt_rel", IDLE, 1'b0);
    mem_req = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
`ifdef PIPE_HAZARD_PERF_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd2);
    chk("flush_cnt", 32'(flush_cnt), 32'd1);
`else
    chk("stall_cnt", 32'(stall_cnt), 32'd0);
    chk("flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
